// File: rtl/ice40_io_pkg.sv
// Shared pin-type codes and pad-drive decode for the iCE40 I/O cell model.
package ice40_io_pkg;

    typedef logic [5:0] pin_type_t;

    localparam logic [3:0] PIN_NO_OUTPUT         = 4'b0000;
    localparam logic [3:0] PIN_OUTPUT            = 4'b0110;
    localparam logic [3:0] PIN_OUTPUT_TRISTATE   = 4'b1010;
    localparam logic [3:0] PIN_OUTPUT_REGISTERED = 4'b0101;
    localparam logic [3:0] PIN_OUTPUT_DDR        = 4'b0100;

    localparam logic [1:0] PIN_INPUT_REGISTERED  = 2'b00;
    localparam logic [1:0] PIN_INPUT             = 2'b01;

    function automatic logic out_mode_valid(input logic [3:0] mode);
        return (mode == PIN_NO_OUTPUT)         || (mode == PIN_OUTPUT) ||
               (mode == PIN_OUTPUT_TRISTATE)   || (mode == PIN_OUTPUT_REGISTERED) ||
               (mode == PIN_OUTPUT_DDR);
    endfunction

    // True when the cell actively drives the pads in the given output mode.
    function automatic logic pad_drive_en(input logic [3:0] mode, input logic oe);
        logic en;
        en = 1'b0;
        case (mode)
            PIN_OUTPUT, PIN_OUTPUT_REGISTERED, PIN_OUTPUT_DDR: en = 1'b1;
            PIN_OUTPUT_TRISTATE:                               en = oe;
            default:                                           en = 1'b0;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/ice40_io_cell_model_bit.sv
// One pad of the I/O cell: output registering/DDR mux and input capture.
// Optional negedge input capture on d_in_1_o when SBIO_DDR_INPUT_EN is defined.
module ice40_io_bit
    import ice40_io_pkg::*;
#(
    parameter pin_type_t PIN_TYPE = 6'b000000
) (
    input  logic clk,
    input  logic reset_i,
    input  logic pad_i,
    input  logic d_out_0_i,
    input  logic d_out_1_i,
    output logic pad_o,
    output logic d_in_0_o,
    output logic d_in_1_o
);

    localparam logic [3:0] OUT_MODE = PIN_TYPE[5:2];
    localparam logic       IN_REG   = (PIN_TYPE[1:0] == PIN_INPUT_REGISTERED);

    logic r0_q;
    logic r1p_q;
    logic r1_q;
    logic din0_q;
    logic rst_q;

    always_ff @(posedge clk) begin
        rst_q <= reset_i;
        if (reset_i) begin
            r0_q   <= 1'b0;
            r1p_q  <= 1'b0;
            din0_q <= 1'b0;
        end else begin
            r0_q   <= d_out_0_i;
            r1p_q  <= d_out_1_i;
            din0_q <= pad_i;
        end
    end

    // Falling-edge half of the DDR pair; reset lands one negedge after the posedge.
    always_ff @(negedge clk) begin
        r1_q <= rst_q ? 1'b0 : r1p_q;
    end

    always_comb begin
        pad_o = 1'b0;
        case (OUT_MODE)
            PIN_OUTPUT, PIN_OUTPUT_TRISTATE: pad_o = d_out_0_i;
            PIN_OUTPUT_REGISTERED:           pad_o = r0_q;
            PIN_OUTPUT_DDR:                  pad_o = clk ? r0_q : r1_q;
            default:                         pad_o = 1'b0;
        endcase
    end

    assign d_in_0_o = IN_REG ? din0_q : pad_i;

`ifdef SBIO_DDR_INPUT_EN
    logic din1_q;

    always_ff @(negedge clk) begin
        din1_q <= rst_q ? 1'b0 : pad_i;
    end

    assign d_in_1_o = din1_q;
`else
    assign d_in_1_o = 1'b0;
`endif

endmodule

// File: rtl/ice40_io_cell_model.sv
// Behavioural iCE40 I/O cell over a WIDTH-bit pad group with shared clock and OE.
// Negedge input capture on d_in_1_o is built only with SBIO_DDR_INPUT_EN defined.
module ice40_io_cell_model
    import ice40_io_pkg::*;
#(
    parameter pin_type_t   PIN_TYPE = 6'b000000,
    parameter int unsigned WIDTH    = 1
) (
    input  logic             clk,
    input  logic             reset_i,
    inout  wire  [WIDTH-1:0] package_pin,
    input  logic             output_enable_i,
    input  logic [WIDTH-1:0] d_out_0_i,
    input  logic [WIDTH-1:0] d_out_1_i,
    output logic [WIDTH-1:0] d_in_0_o,
    output logic [WIDTH-1:0] d_in_1_o
);

    logic [WIDTH-1:0] pad_out;
    logic             drive_en;

    if (PIN_TYPE[1]) begin : g_latched_warn
        $warning("ice40_io_cell_model: latched input mode modelled as combinational");
    end

    if (!out_mode_valid(PIN_TYPE[5:2])) begin : g_mode_warn
        $warning("ice40_io_cell_model: unsupported output mode, pads left undriven");
    end

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        ice40_io_bit #(
            .PIN_TYPE (PIN_TYPE)
        ) u_bit (
            .clk       (clk),
            .reset_i   (reset_i),
            .pad_i     (package_pin[i]),
            .d_out_0_i (d_out_0_i[i]),
            .d_out_1_i (d_out_1_i[i]),
            .pad_o     (pad_out[i]),
            .d_in_0_o  (d_in_0_o[i]),
            .d_in_1_o  (d_in_1_o[i])
        );
    end

    // Drive enable is common to every bit: mode and OE are shared by the group.
    assign drive_en    = pad_drive_en(PIN_TYPE[5:2], output_enable_i);
    assign package_pin = drive_en ? pad_out : {WIDTH{1'bz}};

endmodule

// File: tb/tb_ice40_io_cell_model.sv
// Directed bench for ice40_io_cell_model across tri-state, input-only, DDR,
// registered-output and combinational-input pin types.
`timescale 1ns/1ps
module tb_ice40_io_cell_model;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_i;
    logic oe;

    // Tri-state out, registered in, 8 bits
    logic [7:0]  dout_tri, ext_tri, din0_tri, din1_tri;
    logic        ext_en_tri;
    wire  [7:0]  pad_tri;
    assign pad_tri = ext_en_tri ? ext_tri : 8'bz;

    // No output, registered in, 7 bits
    logic [6:0]  ext_in, din0_in, din1_in;
    wire  [6:0]  pad_in;
    assign pad_in = ext_in;

    // DDR out, 1 bit
    logic        dout0_ddr, dout1_ddr, din0_ddr, din1_ddr;
    wire         pad_ddr;

    // Registered out, registered in, 15 bits
    logic [14:0] dout_reg, din0_reg, din1_reg;
    wire  [14:0] pad_reg;

    // No output, combinational in, 1 bit
    logic        ext_comb, din0_comb, din1_comb;
    wire         pad_comb;
    assign pad_comb = ext_comb;

    ice40_io_cell_model #(.PIN_TYPE(6'b101000), .WIDTH(8)) u_tri (
        .clk(clk), .reset_i(reset_i), .package_pin(pad_tri), .output_enable_i(oe),
        .d_out_0_i(dout_tri), .d_out_1_i(8'h00), .d_in_0_o(din0_tri), .d_in_1_o(din1_tri));

    ice40_io_cell_model #(.PIN_TYPE(6'b000000), .WIDTH(7)) u_in (
        .clk(clk), .reset_i(reset_i), .package_pin(pad_in), .output_enable_i(oe),
        .d_out_0_i(7'h00), .d_out_1_i(7'h00), .d_in_0_o(din0_in), .d_in_1_o(din1_in));

    ice40_io_cell_model #(.PIN_TYPE(6'b010000), .WIDTH(1)) u_ddr (
        .clk(clk), .reset_i(reset_i), .package_pin(pad_ddr), .output_enable_i(oe),
        .d_out_0_i(dout0_ddr), .d_out_1_i(dout1_ddr), .d_in_0_o(din0_ddr), .d_in_1_o(din1_ddr));

    ice40_io_cell_model #(.PIN_TYPE(6'b010100), .WIDTH(15)) u_reg (
        .clk(clk), .reset_i(reset_i), .package_pin(pad_reg), .output_enable_i(oe),
        .d_out_0_i(dout_reg), .d_out_1_i(15'h0000), .d_in_0_o(din0_reg), .d_in_1_o(din1_reg));

    ice40_io_cell_model #(.PIN_TYPE(6'b000001), .WIDTH(1)) u_comb (
        .clk(clk), .reset_i(reset_i), .package_pin(pad_comb), .output_enable_i(oe),
        .d_out_0_i(1'b0), .d_out_1_i(1'b0), .d_in_0_o(din0_comb), .d_in_1_o(din1_comb));

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [6:0] exp_ddr_in;

    initial begin
        reset_i    = 1'b1;
        oe         = 1'b0;
        dout_tri   = 8'h00;
        ext_tri    = 8'h00;
        ext_en_tri = 1'b0;
        ext_in     = 7'h00;
        dout0_ddr  = 1'b0;
        dout1_ddr  = 1'b0;
        dout_reg   = 15'h0000;
        ext_comb   = 1'b0;
`ifdef SBIO_DDR_INPUT_EN
        exp_ddr_in = 7'h7F;
`else
        exp_ddr_in = 7'h00;
`endif

        repeat (2) @(posedge clk);
        #1;
        reset_i = 1'b0;
        check("rst_din0_tri", 32'(din0_tri), 32'h0);
        check("rst_din0_in",  32'(din0_in),  32'h0);
        check("rst_pad_reg",  32'(pad_reg),  32'h0);
        check("rst_din0_reg", 32'(din0_reg), 32'h0);
        check("rst_din0_ddr", 32'(din0_ddr), 32'h0);
        check("rst_din0_comb", 32'(din0_comb), 32'h0);
        check("rst_din1_tri", 32'(din1_tri), 32'h0);
        check("rst_din1_in",  32'(din1_in),  32'h0);
        check("rst_din1_ddr", 32'(din1_ddr), 32'h0);
        check("rst_din1_reg", 32'(din1_reg), 32'h0);
        check("rst_din1_comb", 32'(din1_comb), 32'h0);

        oe        = 1'b1;
        dout_tri  = 8'hA5;
        dout_reg  = 15'h1234;
        dout0_ddr = 1'b0;
        dout1_ddr = 1'b1;
        ext_in    = 7'h55;
        #1;
        check("tri_pad_same_cycle", 32'(pad_tri), 32'hA5);

        @(posedge clk); #1;
        check("tri_loopback", 32'(din0_tri), 32'hA5);
        check("reg_pad_1cyc", 32'(pad_reg), 32'h1234);
        check("in_lag_55", 32'(din0_in), 32'h55);
        check("ddr_clk_high_0", 32'(pad_ddr), 32'h0);
        oe         = 1'b0;
        ext_en_tri = 1'b1;
        ext_tri    = 8'h3C;
        ext_in     = 7'h2A;
        #1;
        check("tri_released_ext", 32'(pad_tri), 32'h3C);

        @(negedge clk); #1;
        check("ddr_clk_low_0", 32'(pad_ddr), 32'h1);
        check("in_hold_55", 32'(din0_in), 32'h55);

        @(posedge clk); #1;
        check("tri_ext_capture", 32'(din0_tri), 32'h3C);
        check("in_lag_2a", 32'(din0_in), 32'h2A);
        check("reg_loopback", 32'(din0_reg), 32'h1234);
        check("ddr_clk_high_1", 32'(pad_ddr), 32'h0);

        reset_i    = 1'b1;
        ext_en_tri = 1'b0;
        oe         = 1'b1;
        dout_tri   = 8'h5A;
        #1;
        check("tri_follows_in_reset", 32'(pad_tri), 32'h5A);

        @(posedge clk); #1;
        check("reg_pad_reset", 32'(pad_reg), 32'h0);
        check("tri_din_reset", 32'(din0_tri), 32'h0);
        reset_i = 1'b0;

        @(posedge clk); #1;
        check("reg_pad_resume", 32'(pad_reg), 32'h1234);
        check("tri_din_resume", 32'(din0_tri), 32'h5A);

        for (int i = 0; i < 4; i++) begin
            check("ddr_loop_high", 32'(pad_ddr), 32'h0);
            @(negedge clk); #1;
            check("ddr_loop_low", 32'(pad_ddr), 32'h1);
            @(posedge clk); #1;
        end

        ext_comb = 1'b1;
        #1;
        check("comb_rise", 32'(din0_comb), 32'h1);
        ext_comb = 1'b0;
        #1;
        check("comb_fall", 32'(din0_comb), 32'h0);

        @(posedge clk); #1;
        ext_in = 7'h7F;
        @(negedge clk); #1;
        ext_in = 7'h00;
        @(posedge clk); #1;
        check("ddr_in_negedge", 32'(din1_in), 32'(exp_ddr_in));
        check("ddr_in_posedge", 32'(din0_in), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ice40_io_cell_model.md
Name: ice40_io_cell_model

Overview:
- Behavioural, simulation-friendly model of an iCE40 I/O cell.
- Used in non-synthesis builds in place of the vendor pad primitive, for data-bus pads, bus control inputs and DVI outputs.
- Replicates the PIN_TYPE-selected input/output registering, tri-state and DDR-output behaviour on a WIDTH-bit group of pads sharing one clock and one output enable.

Parameters:
- PIN_TYPE, 6'b000000, iCE40 pin-type code: [5:2] output mode, [1:0] input mode.
- WIDTH, 1, number of pads in the group (1..32).

Ports:
- clk  input  1  cell clock; posedge and negedge both used.
- reset_i  input  1  synchronous, active-high reset.
- package_pin  inout  WIDTH  physical pads.
- output_enable_i  input  1  shared tri-state enable, active-high.
- d_out_0_i  input  WIDTH  output data; rising-edge half in DDR mode.
- d_out_1_i  input  WIDTH  falling-edge-half output data (DDR mode only).
- d_in_0_o  output  WIDTH  input data seen by the core.
- d_in_1_o  output  WIDTH  negedge-captured input data; 0 unless optional feature enabled.

Behaviour:
- Reset: every register cleared at the posedge with reset_i=1; d_in_0_o/d_in_1_o read 0 from the next cycle. The DDR negedge register clears at the following negedge.
- Input mode PIN_TYPE[1:0]:
  - 2'b00 registered: d_in_0_o <= package_pin at each posedge (1-cycle latency).
  - 2'b01 combinational: d_in_0_o = package_pin.
  - 2'b1x (latched): treated as 2'b01; elaboration $warning.
- Output mode PIN_TYPE[5:2]:
  - 4'b0000 none: pad undriven (Z).
  - 4'b0110 simple: pad = d_out_0_i combinationally, always driven.
  - 4'b1010 tri-state: pad = output_enable_i ? d_out_0_i : Z, combinational.
  - 4'b0101 registered: r0 <= d_out_0_i at posedge; pad = r0, always driven.
  - 4'b0100 DDR:
    - r0 <= d_out_0_i and r1p <= d_out_1_i at posedge; r1 <= r1p at negedge.
    - pad = clk ? r0 : r1.
    - With d_out_0_i=0, d_out_1_i=1 the pad is the inverted clock.
  - Any other code: pad Z; elaboration $warning.
- Loopback: with the pad driven by the cell, input capture sees the driven value (registered mode: next posedge).
- During reset:
  - Registered/DDR pads drive 0.
  - Combinational and tri-state pads still follow their inputs.
- Z/X on the pad propagate unmodified to d_in_0_o; no pull-up.
- All bits are independent; output_enable_i applies to all bits.

Optional Feature:
- Macro: SBIO_DDR_INPUT_EN.
- Defined:
  - d_in_1_o <= package_pin at each negedge (cleared by reset at the next negedge).
  - In registered input mode, d_in_0_o remains the posedge capture.
- Undefined: d_in_1_o tied to 0; no negedge input register exists.

Decomposition:
- Shared package ice40_io_pkg holds:
  - localparams PIN_NO_OUTPUT=4'b0000, PIN_OUTPUT=4'b0110, PIN_OUTPUT_TRISTATE=4'b1010, PIN_OUTPUT_REGISTERED=4'b0101, PIN_OUTPUT_DDR=4'b0100;
  - PIN_INPUT_REGISTERED=2'b00, PIN_INPUT=2'b01;
  - a pin_type_t 6-bit typedef.
- One sub-module ice40_io_bit implements a single pad; the top generate-loops WIDTH instances.

Test Plan:
- PIN_TYPE=6'b101000, WIDTH=8, oe=1, d_out_0=8'hA5 -> pad=8'hA5 same cycle; d_in_0_o=8'hA5 one posedge later; oe=0 -> pad 8'hZZ; external drive 8'h3C -> d_in_0_o=8'h3C after one posedge.
- PIN_TYPE=6'b000000, WIDTH=7, pad driven 7'h55 then 7'h2A -> d_in_0_o tracks with exactly one-cycle lag; pad never driven by the cell.
- PIN_TYPE=6'b010000, d_out_0=0, d_out_1=1, after reset -> pad low while clk high, high while clk low, every cycle.
- PIN_TYPE=6'b010100, WIDTH=15, d_out_0=15'h1234 -> pad=15'h1234 one posedge later; reset_i pulse -> pad 0 next posedge, then resumes.
- PIN_TYPE=6'b000001, pad toggled mid-cycle -> d_in_0_o changes same delta, no clock needed.
- With SBIO_DDR_INPUT_EN: pad=1 before negedge, pad=0 before posedge -> d_in_1_o=1, d_in_0_o=0; without the macro d_in_1_o stays 0.
